regfile_bank_config: RTL

Parametrised register bank for the accelerator's register interface. It replaces the hand-expanded per-group regfiles with one generic block that provides:
- NUM_RW read/write configuration registers
- a write-one-shot command register that emits true single-cycle pulses
- a sticky clear-on-read status register with a maskable interrupt
- a registered read path

Each block instance sits behind the register-interface decoder and drives one functional group: general config, buffer control, or PE array.

---
 rtl/regfile_bank_config.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_bank_config.sv
// regfile_bank_config: generic register bank for one register-interface group.
// Contents: NUM_RW read/write config registers, a write-one-shot command register
// (single-cycle pulses), a sticky clear-on-read status register with a maskable
// interrupt, and a registered read path.
// Optional feature: define REGFILE_BANK_WR_LOCK_EN to add a set-once LOCK register
// at BASE_ADDR+NUM_RW+3. While it is set, writes to the RW registers and IRQ_MASK
// are blocked.
module regfile_bank_config #(
  parameter int unsigned        ADDR_W    = 14,
  parameter int unsigned        DATA_W    = 16,
  parameter int unsigned        NUM_RW    = 4,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(1),
  parameter int unsigned        CMD_W     = 10,
  parameter int unsigned        STS_W     = 2,
  parameter logic [DATA_W-1:0]  RST_VAL   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        write_data,
  output logic [DATA_W-1:0]        read_data,
  output logic                     rd_valid,
  output logic                     addr_hit,
  output logic [NUM_RW*DATA_W-1:0] cfg_regs,
  output logic [CMD_W-1:0]         cmd_pulse,
  input  logic [STS_W-1:0]         sts_set,
  output logic [STS_W-1:0]         sts_q,
  output logic                     irq
);

  // Register offsets following the RW block; all arithmetic is kept in ADDR_W bits.
  localparam logic [ADDR_W-1:0] A_CMD = BASE_ADDR + ADDR_W'(NUM_RW);
  localparam logic [ADDR_W-1:0] A_STS = A_CMD + ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_MSK = A_CMD + ADDR_W'(2);
`ifdef REGFILE_BANK_WR_LOCK_EN
  localparam logic [ADDR_W-1:0] A_LOCK = A_CMD + ADDR_W'(3);
`endif

  // The whole map, including the LOCK slot, must fit in the address space.
  localparam logic [63:0] LAST_ADDR = 64'(BASE_ADDR) + 64'(NUM_RW) + 64'd3;
  localparam logic [63:0] MAX_ADDR  = (64'd1 << ADDR_W) - 64'd1;

  generate
    if (LAST_ADDR > MAX_ADDR) begin : g_addr_overflow
      $error("regfile_bank_config: BASE_ADDR+NUM_RW+3 overflows ADDR_W");
    end
    if (NUM_RW < 1 || NUM_RW > 64) begin : g_num_rw_range
      $error("regfile_bank_config: NUM_RW must be 1..64");
    end
    if (CMD_W > DATA_W || STS_W > DATA_W) begin : g_field_width
      $error("regfile_bank_config: CMD_W and STS_W must not exceed DATA_W");
    end
  endgenerate

  logic [DATA_W-1:0] cfg_q [NUM_RW];
  logic [NUM_RW-1:0] rw_sel;
  logic [STS_W-1:0]  irq_mask;
  logic [DATA_W-1:0] rd_mux;
  logic              rd_hit;
  logic              sts_clr;
  logic              wr_ok;

`ifdef REGFILE_BANK_WR_LOCK_EN
  logic lock_q;

  // Lock is set-once; only reset can clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else if (wr_en && addr == A_LOCK && write_data[0]) begin
      lock_q <= 1'b1;
    end
  end

  assign wr_ok = ~lock_q;
`else
  assign wr_ok = 1'b1;
`endif

  // Decode the RW register selects.
  always_comb begin
    rw_sel = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      rw_sel[i] = (addr == BASE_ADDR + ADDR_W'(i));
    end
  end

  // Read mux. CMD is mapped but always reads 0; narrow fields are zero-extended.
  always_comb begin
    rd_mux = '0;
    rd_hit = 1'b0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (rw_sel[i]) begin
        rd_mux = cfg_q[i];
        rd_hit = 1'b1;
      end
    end
    if (addr == A_CMD) begin
      rd_hit = 1'b1;
    end
    if (addr == A_STS) begin
      rd_mux = DATA_W'(sts_q);
      rd_hit = 1'b1;
    end
    if (addr == A_MSK) begin
      rd_mux = DATA_W'(irq_mask);
      rd_hit = 1'b1;
    end
`ifdef REGFILE_BANK_WR_LOCK_EN
    if (addr == A_LOCK) begin
      rd_mux = DATA_W'(lock_q);
      rd_hit = 1'b1;
    end
`endif
  end

  assign sts_clr = rd_en && (addr == A_STS);

  // RW configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RW; i++) begin
        cfg_q[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (wr_en && wr_ok && rw_sel[i]) begin
          cfg_q[i] <= write_data;
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_RW; g++) begin : g_cfg_out
      assign cfg_regs[g*DATA_W +: DATA_W] = cfg_q[g];
    end
  endgenerate

  // Interrupt mask keeps only the status-width bits; the rest are dropped on write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_mask <= '0;
    end else if (wr_en && wr_ok && addr == A_MSK) begin
      irq_mask <= write_data[STS_W-1:0];
    end
  end

  // Command pulses live for exactly the cycle after the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_pulse <= '0;
    end else if (wr_en && addr == A_CMD) begin
      cmd_pulse <= write_data[CMD_W-1:0];
    end else begin
      cmd_pulse <= '0;
    end
  end

  // Sticky status: a new set beats a clear-on-read in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sts_q <= '0;
    end else begin
      sts_q <= (sts_q & ~{STS_W{sts_clr}}) | sts_set;
    end
  end

  // Interrupt is registered from the current status, so it trails sts_q by a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= |(sts_q & irq_mask);
    end
  end

  // Registered read response; data and hit hold between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
      rd_valid  <= 1'b0;
      addr_hit  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        read_data <= rd_mux;
        addr_hit  <= rd_hit;
      end
    end
  end

endmodule
